padding: RTL and testbench

//   Zero-pads every channel of a flattened D x H x W feature map by P elements on all four sides.
//   The result is a D x (H+2P) x (W+2P) map.

---
 rtl/padding.sv | 48 ++++
 tb/tb_padding.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/padding.sv
// Zero-pads each channel of a flattened D x H x W map by P elements on every side.
// The padded map is registered, so latency is one clock and a new image is accepted every clock.
module padding #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 1,
  parameter int unsigned H          = 10,
  parameter int unsigned W          = 10,
  parameter int unsigned P          = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [0:D*H*W*DATA_WIDTH-1]                 image_in,
  output logic [0:D*(H+2*P)*(W+2*P)*DATA_WIDTH-1]     image_out
);

  localparam int unsigned HO     = H + 2 * P;
  localparam int unsigned WO     = W + 2 * P;
  localparam int unsigned M_BITS = D * HO * WO * DATA_WIDTH;

  logic [0:M_BITS-1] padded_c;

  // Static routing: interior elements come from the input, border elements are tied to zero.
  for (genvar d = 0; d < int'(D); d++) begin : g_ch
    for (genvar r = 0; r < int'(HO); r++) begin : g_row
      for (genvar c = 0; c < int'(WO); c++) begin : g_col
        localparam int          RI = r - int'(P);
        localparam int          CI = c - int'(P);
        localparam int unsigned EO = (int'(d) * HO + int'(r)) * WO + int'(c);
        if (RI >= 0 && RI < int'(H) && CI >= 0 && CI < int'(W)) begin : g_interior
          localparam int unsigned EI = (int'(d) * H + RI) * W + CI;
          assign padded_c[EO*DATA_WIDTH +: DATA_WIDTH] = image_in[EI*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_border
          assign padded_c[EO*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
    end
  end

  // Output register bank with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      image_out <= '0;
    end else begin
      image_out <= padded_c;
    end
  end

endmodule

// File: tb/tb_padding.sv
// Scoreboard bench for padding: three configurations driven in lockstep,
// expected images from a loop-based reference, checked by an independent monitor.
module tb_padding;

  localparam int unsigned DW   = 16;
  localparam int unsigned MAXE = 196;
  localparam int unsigned MAXB = MAXE * DW;

  // Configuration 0: defaults (1x10x10, P=2)
  localparam int unsigned N0 = 100;
  localparam int unsigned M0 = 196;
  // Configuration 1: 3x4x4, P=1
  localparam int unsigned N1 = 48;
  localparam int unsigned M1 = 108;
  // Configuration 2: 1x3x3, P=0
  localparam int unsigned N2 = 9;
  localparam int unsigned M2 = 9;

  typedef logic [0:MAXB-1] vec_t;
  typedef struct {
    vec_t e0;
    vec_t e1;
    vec_t e2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:N0*DW-1] in0 = '0;
  logic [0:M0*DW-1] out0;
  logic [0:N1*DW-1] in1 = '0;
  logic [0:M1*DW-1] out1;
  logic [0:N2*DW-1] in2 = '0;
  logic [0:M2*DW-1] out2;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;

  always #5 clk = ~clk;

  padding #(.DATA_WIDTH(DW), .D(1), .H(10), .W(10), .P(2)) dut0 (
    .clk(clk), .rst(rst), .image_in(in0), .image_out(out0));
  padding #(.DATA_WIDTH(DW), .D(3), .H(4), .W(4), .P(1)) dut1 (
    .clk(clk), .rst(rst), .image_in(in1), .image_out(out1));
  padding #(.DATA_WIDTH(DW), .D(1), .H(3), .W(3), .P(0)) dut2 (
    .clk(clk), .rst(rst), .image_in(in2), .image_out(out2));

  // Reference: walk every output coordinate, copy from the shifted input coordinate when in range.
  function automatic vec_t pad_ref(vec_t src, int d, int h, int w, int p);
    vec_t o;
    int ho;
    int wo;
    int ri;
    int ci;
    o  = '0;
    ho = h + 2 * p;
    wo = w + 2 * p;
    for (int ch = 0; ch < d; ch++)
      for (int r = 0; r < ho; r++)
        for (int c = 0; c < wo; c++) begin
          ri = r - p;
          ci = c - p;
          if (ri >= 0 && ri < h && ci >= 0 && ci < w)
            o[((ch * ho + r) * wo + c) * 16 +: 16] = src[((ch * h + ri) * w + ci) * 16 +: 16];
        end
    return o;
  endfunction

  function automatic vec_t rand_img(int n);
    vec_t v;
    v = '0;
    for (int e = 0; e < n; e++) v[e*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  function automatic vec_t fill_img(int n, logic [15:0] val);
    vec_t v;
    v = '0;
    for (int e = 0; e < n; e++) v[e*16 +: 16] = val;
    return v;
  endfunction

  task automatic sample(output vec_t a0, output vec_t a1, output vec_t a2);
    a0 = '0; a1 = '0; a2 = '0;
    a0[0:M0*DW-1] = out0;
    a1[0:M1*DW-1] = out1;
    a2[0:M2*DW-1] = out2;
  endtask

  task automatic compare_vec(string name, vec_t act, vec_t exp, int m);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int e = 0; e < m; e++)
        if (act[e*16 +: 16] !== exp[e*16 +: 16]) begin
          $display("FAIL %s @%0t: element %0d got %h expected %h", name, $time, e,
                   act[e*16 +: 16], exp[e*16 +: 16]);
          break;
        end
    end
  endtask

  task automatic check_elem(string name, int e, logic [15:0] exp);
    vec_t a0, a1, a2;
    sample(a0, a1, a2);
    checks++;
    if (a0[e*16 +: 16] !== exp) begin
      errors++;
      $display("FAIL %s: element %0d got %h expected %h", name, e, a0[e*16 +: 16], exp);
    end
  endtask

  // Drive one cycle of stimulus and record what each DUT must show after the next edge.
  task automatic step(input logic r, input vec_t s0, input vec_t s1, input vec_t s2);
    exp_t x;
    @(negedge clk);
    rst = r;
    in0 = s0[0:N0*DW-1];
    in1 = s1[0:N1*DW-1];
    in2 = s2[0:N2*DW-1];
    x.e0 = r ? '0 : pad_ref(s0, 1, 10, 10, 2);
    x.e1 = r ? '0 : pad_ref(s1, 3, 4, 4, 1);
    x.e2 = r ? '0 : pad_ref(s2, 1, 3, 3, 0);
    sb.push_back(x);
  endtask

  // Monitor: after each edge, pop the expected result for the stimulus that edge sampled.
  always @(posedge clk) begin
    vec_t a0, a1, a2;
    #2;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      have_cur = 1'b1;
      sample(a0, a1, a2);
      compare_vec("dut0_edge", a0, cur.e0, M0);
      compare_vec("dut1_edge", a1, cur.e1, M1);
      compare_vec("dut2_edge", a2, cur.e2, M2);
    end
  end

  // Hold monitor: right after inputs change, outputs must still show the last registered result.
  always @(negedge clk) begin
    vec_t a0, a1, a2;
    #1;
    if (have_cur) begin
      sample(a0, a1, a2);
      compare_vec("dut0_hold", a0, cur.e0, M0);
      compare_vec("dut1_hold", a1, cur.e1, M1);
      compare_vec("dut2_hold", a2, cur.e2, M2);
    end
  end

  initial begin
    vec_t ramp;
    vec_t chan;
    vec_t k4;

    ramp = '0;
    for (int e = 0; e < 100; e++) ramp[e*16 +: 16] = 16'(e);
    chan = '0;
    for (int k = 0; k < 3; k++)
      for (int e = 0; e < 16; e++) chan[(k*16 + e)*16 +: 16] = 16'(k + 1);
    k4 = fill_img(100, 16'h4444);

    // Reset two cycles, then one normal cycle with a constant image.
    step(1'b1, k4, chan, rand_img(9));
    step(1'b1, k4, chan, rand_img(9));
    step(1'b0, k4, chan, rand_img(9));
    @(posedge clk); #3;
    check_elem("const_corner", 0, 16'h0000);
    check_elem("const_border_row1", 14 + 5, 16'h0000);
    check_elem("const_border_col13", 5 * 14 + 13, 16'h0000);
    check_elem("const_interior_first", 2 * 14 + 2, 16'h4444);
    check_elem("const_interior_last", 11 * 14 + 11, 16'h4444);

    // Ordering pattern.
    step(1'b0, ramp, chan, rand_img(9));
    @(posedge clk); #3;
    check_elem("order_elem0", 0, 16'h0000);
    check_elem("order_2_2", 2 * 14 + 2, 16'h0000);
    check_elem("order_2_3", 2 * 14 + 3, 16'h0001);
    check_elem("order_3_2", 3 * 14 + 2, 16'h000A);
    check_elem("order_11_11", 11 * 14 + 11, 16'h0063);

    // Back-to-back changes, then a single-cycle reset mid-stream.
    step(1'b0, rand_img(100), rand_img(48), rand_img(9));
    step(1'b0, rand_img(100), rand_img(48), rand_img(9));
    step(1'b1, rand_img(100), rand_img(48), rand_img(9));
    step(1'b0, rand_img(100), rand_img(48), rand_img(9));

    // Random traffic with occasional resets.
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 9) == 0), rand_img(100), rand_img(48), rand_img(9));
    step(1'b0, k4, chan, rand_img(9));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(negedge clk); #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
